// File: rtl/ex_pipe_if.sv
// Operation/result bundle for ex_pipe: master drives operations and consumes
// results, slave (the pipe) accepts operations and presents results.
interface ex_pipe_if #(
  parameter int WIDTH = 32
);
  // Handshake rule: a beat transfers on a rising clk edge when valid and ready
  // are both high; the valid side holds its payload steady until that edge, and
  // ready never depends on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pra;
  logic [WIDTH-1:0] prb;
  logic [WIDTH-1:0] se;
  logic             s_mxse;
  logic [4:0]       op_alu;
  logic [2:0]       op_tf;
  logic [1:0]       cond;
  logic             w_dm;
  logic             w_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] dm_q;
  logic             tf_out;
  logic [3:0]       flags;

  modport master (
    output in_valid, pra, prb, se, s_mxse, op_alu, op_tf, cond, w_dm, w_flags, out_ready,
    input  in_ready, out_valid, result, dm_q, tf_out, flags
  );

  modport slave (
    input  in_valid, pra, prb, se, s_mxse, op_alu, op_tf, cond, w_dm, w_flags, out_ready,
    output in_ready, out_valid, result, dm_q, tf_out, flags
  );
endinterface

// File: rtl/ex_pipe.sv
// Execute stage: ALU, flag register, transfer-flag logic and data memory.
// Define EX_PIPE_MUL_EN to add the iterative shift-add multiplier (OP_ALU=8).
module ex_pipe #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_pipe_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_PB  = 5'd5;
  localparam logic [4:0] OP_SLL = 5'd6;
  localparam logic [4:0] OP_SRL = 5'd7;

  logic [1:0]        state;
  logic [WIDTH-1:0]  mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    sub_sum;
  logic              alu_c;
  logic              alu_o;
  logic [3:0]        new_flags;
  logic              sel_flag;
  logic              tf_val;
  logic              accept;

`ifdef EX_PIPE_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [4:0] OP_MUL = 5'd8;
  localparam int         CNT_W  = $clog2(WIDTH);

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_next;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_wf;

  assign mul_next = mul_acc + (mul_b[0] ? mul_a : '0);
`endif

  assign dbg_state    = state;
  assign addr         = bus.prb[ADDR_W-1:0];
  assign opb          = bus.s_mxse ? bus.se : bus.prb;
  assign bus.in_ready = rst_n && ((state == S_IDLE) || ((state == S_HOLD) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign add_sum      = {1'b0, bus.pra} + {1'b0, opb};
  assign sub_sum      = {1'b0, bus.pra} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (bus.op_alu)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_o   = (bus.pra[WIDTH-1] == opb[WIDTH-1]) && (add_sum[WIDTH-1] != bus.pra[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_o   = (bus.pra[WIDTH-1] != opb[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.pra[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.pra & opb;
      OP_OR:   alu_res = bus.pra | opb;
      OP_XOR:  alu_res = bus.pra ^ opb;
      OP_PB:   alu_res = opb;
      OP_SLL:  alu_res = bus.pra << opb[4:0];
      OP_SRL:  alu_res = bus.pra >> opb[4:0];
      default: alu_res = '0;
    endcase
    new_flags = {alu_o, alu_res[WIDTH-1], alu_c, (alu_res == '0)};
  end

  // Transfer flag reads the flag register as it stands before this op updates it.
  always_comb begin
    case (bus.cond)
      2'd0:    sel_flag = bus.flags[3];
      2'd1:    sel_flag = bus.flags[2];
      2'd2:    sel_flag = bus.flags[1];
      default: sel_flag = bus.flags[0];
    endcase
    case (bus.op_tf)
      3'd0:    tf_val = 1'b0;
      3'd1:    tf_val = 1'b1;
      3'd2:    tf_val = sel_flag;
      3'd3:    tf_val = ~sel_flag;
      default: tf_val = 1'b0;
    endcase
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.w_dm) mem[addr] <= bus.pra;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.dm_q      <= '0;
      bus.tf_out    <= 1'b0;
      bus.flags     <= 4'b0000;
`ifdef EX_PIPE_MUL_EN
      mul_a         <= '0;
      mul_b         <= '0;
      mul_acc       <= '0;
      mul_cnt       <= '0;
      mul_wf        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            bus.dm_q   <= mem[addr];
            bus.tf_out <= tf_val;
`ifdef EX_PIPE_MUL_EN
            if (bus.op_alu == OP_MUL) begin
              state         <= S_MUL;
              bus.out_valid <= 1'b0;
              mul_a         <= bus.pra;
              mul_b         <= opb;
              mul_acc       <= '0;
              mul_cnt       <= '0;
              mul_wf        <= bus.w_flags;
            end else
`endif
            begin
              state         <= S_HOLD;
              bus.out_valid <= 1'b1;
              bus.result    <= alu_res;
              if (bus.w_flags) bus.flags <= new_flags;
            end
          end else if ((state == S_HOLD) && bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
`ifdef EX_PIPE_MUL_EN
        // One multiplier bit per cycle; the WIDTH-th step lands the product.
        S_MUL: begin
          mul_acc <= mul_next;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_W'(WIDTH - 1)) begin
            state         <= S_HOLD;
            bus.out_valid <= 1'b1;
            bus.result    <= mul_next;
            if (mul_wf) bus.flags <= {1'b0, mul_next[WIDTH-1], 1'b0, (mul_next == '0)};
          end
        end
`endif
        default: begin
          state         <= S_IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
